// File: rtl/unified_mem_arbiter_if.sv
// Requester and memory-side signals of the unified memory arbiter.
// The slave view is the arbiter; the master view is the pipeline plus memory around it.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              if_stall;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;
    logic              d_stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_rdata, if_ready, if_stall, d_rdata, d_ready, d_stall,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and data access.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    unified_mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAT_C    = CNT_W'(MEM_LATENCY);
    localparam logic [CNT_W-1:0] STARVE_C = CNT_W'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic              own_data_q, own_data_d;
    logic [CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              if_ready_q, if_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              busy_q, busy_d;
    logic              grant_if, grant_data;

    always_comb begin
        state_d      = state_q;
        own_data_d   = own_data_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        if_ready_d   = 1'b0;
        d_ready_d    = 1'b0;
        grant_if     = 1'b0;
        grant_data   = 1'b0;

        case (state_q)
            IDLE: begin
                grant_if   = bus.if_req && (!bus.d_req || starve_cnt_q == STARVE_C);
                grant_data = bus.d_req && !grant_if;
                if (grant_if || grant_data) begin
                    state_d     = ACCESS;
                    own_data_d  = grant_data;
                    mem_en_d    = 1'b1;
                    lat_cnt_d   = '0;
                    mem_addr_d  = grant_data ? bus.d_addr : bus.if_addr;
                    mem_we_d    = grant_data && bus.d_we;
                    mem_wdata_d = grant_data ? bus.d_wdata : '0;
                    // Only data grants that make a waiting fetch wait longer count toward starvation.
                    if (grant_if) begin
                        starve_cnt_d = '0;
                    end else if (bus.if_req && starve_cnt_q != STARVE_C) begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end
            end
            ACCESS: begin
                lat_cnt_d = lat_cnt_q + 1'b1;
                if (lat_cnt_q == LAT_C) begin
                    state_d = RESP;
                    if (own_data_q) begin
                        d_ready_d = 1'b1;
                        if (!mem_we_q) begin
                            d_rdata_d = bus.mem_rdata;
                        end
                    end else begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            own_data_q   <= 1'b0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            if_ready_q   <= 1'b0;
            d_ready_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            own_data_q   <= own_data_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            if_ready_q   <= if_ready_d;
            d_ready_q    <= d_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.if_rdata  = if_rdata_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.if_stall  = bus.if_req & ~if_ready_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.d_ready   = d_ready_q;
    assign bus.d_stall   = bus.d_req & ~d_ready_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed scenarios plus randomized requesters checked
// against a transaction-timing model; two extra instances cover latencies 1 and 5.
module tb_unified_mem_arbiter;
    localparam int LAT = 2;
    localparam int SL  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus5 ();

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT), .STARVE_LIMIT(SL))
        dut (.clk(clk), .reset(reset), .bus(bus));
    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(SL))
        dut_l1 (.clk(clk), .reset(reset), .bus(bus1));
    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(5), .STARVE_LIMIT(SL))
        dut_l5 (.clk(clk), .reset(reset), .bus(bus5));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Transaction-level model: grant cycle, owner, latched request and expected read data.
    int          g_cyc    = -1000;
    int          nxt_idle = 0;
    int          m_starve = 0;
    logic        m_own_d  = 1'b0;
    logic        m_we     = 1'b0;
    logic [31:0] m_addr   = '0;
    logic [31:0] m_wdata  = '0;
    logic [31:0] m_rval   = '0;
    logic [31:0] m_if_rdata = '0;
    logic [31:0] m_d_rdata  = '0;
    logic        dir_en   = 1'b0;
    logic [31:0] dir_rval = '0;
    logic        s_if_ready = 1'b0;
    logic        s_d_ready  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle of the main instance: entered and left at posedge+1.
    task automatic step();
        logic ex_ifr, ex_dr, fetch_wins;
        bus.mem_rdata = (cyc == g_cyc + 1 + LAT) ? m_rval : 32'($urandom());
        @(negedge clk);
        ex_dr  = (cyc == g_cyc + 2 + LAT) && m_own_d;
        ex_ifr = (cyc == g_cyc + 2 + LAT) && !m_own_d;
        chk("mem_en",   bus.mem_en,   cyc == g_cyc + 1);
        chk("busy",     bus.busy,     (cyc >= g_cyc + 1) && (cyc <= g_cyc + 2 + LAT));
        chk("if_ready", bus.if_ready, ex_ifr);
        chk("d_ready",  bus.d_ready,  ex_dr);
        chk("if_rdata", bus.if_rdata, m_if_rdata);
        chk("d_rdata",  bus.d_rdata,  m_d_rdata);
        chk("if_stall", bus.if_stall, bus.if_req & ~ex_ifr);
        chk("d_stall",  bus.d_stall,  bus.d_req & ~ex_dr);
        if ((cyc >= g_cyc + 1) && (cyc <= g_cyc + 1 + LAT)) begin
            chk("mem_addr",  bus.mem_addr,  m_addr);
            chk("mem_we",    bus.mem_we,    m_we);
            chk("mem_wdata", bus.mem_wdata, m_wdata);
        end
        s_if_ready = bus.if_ready;
        s_d_ready  = bus.d_ready;

        if (reset) begin
            g_cyc      = -1000;
            nxt_idle   = cyc + 1;
            m_starve   = 0;
            m_if_rdata = '0;
            m_d_rdata  = '0;
        end else begin
            if (cyc == g_cyc + 1 + LAT) begin
                if (!m_own_d) m_if_rdata = m_rval;
                else if (!m_we) m_d_rdata = m_rval;
            end
            if (cyc >= nxt_idle && (bus.if_req || bus.d_req)) begin
                fetch_wins = bus.if_req && (!bus.d_req || m_starve == SL);
                g_cyc    = cyc;
                nxt_idle = cyc + 3 + LAT;
                m_own_d  = !fetch_wins;
                m_addr   = fetch_wins ? bus.if_addr : bus.d_addr;
                m_we     = !fetch_wins && bus.d_we;
                m_wdata  = fetch_wins ? 32'h0 : bus.d_wdata;
                m_rval   = dir_en ? dir_rval : 32'($urandom());
                if (fetch_wins) m_starve = 0;
                else if (bus.if_req && m_starve < SL) m_starve++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic dir_txn(input logic ifq, input logic dq, input logic we,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [31:0] rv, input int n);
        dir_en = 1'b1;
        dir_rval = rv;
        bus.if_req = ifq;  bus.if_addr = ia;
        bus.d_req = dq;    bus.d_we = we;  bus.d_addr = da;  bus.d_wdata = wd;
        repeat (n) begin
            step();
            if (s_if_ready) bus.if_req = 1'b0;
            if (s_d_ready)  bus.d_req  = 1'b0;
        end
        dir_en = 1'b0;
    endtask

    initial begin
        logic [31:0] v1, v5;
        reset = 1'b1;
        bus.if_req = 0;  bus.if_addr = 0;  bus.d_req = 0;  bus.d_we = 0;
        bus.d_addr = 0;  bus.d_wdata = 0;  bus.mem_rdata = 0;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0; bus1.mem_rdata = 0;
        bus5.if_req = 0; bus5.if_addr = 0; bus5.d_req = 0; bus5.d_we = 0;
        bus5.d_addr = 0; bus5.d_wdata = 0; bus5.mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_mem_en",    bus.mem_en,    1'b0);
        chk("rst_mem_we",    bus.mem_we,    1'b0);
        chk("rst_mem_addr",  bus.mem_addr,  32'h0);
        chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
        chk("rst_if_rdata",  bus.if_rdata,  32'h0);
        chk("rst_d_rdata",   bus.d_rdata,   32'h0);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_busy_l1",   bus1.busy,     1'b0);
        chk("rst_busy_l5",   bus5.busy,     1'b0);
        repeat (2) step();

        // Single load, then store, then simultaneous fetch and data.
        dir_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h40, 32'h0, 32'hDEADBEEF, 6);
        chk("load_rdata", bus.d_rdata, 32'hDEADBEEF);
        dir_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'h1234, 32'h5555AAAA, 6);
        chk("store_keeps_rdata", bus.d_rdata, 32'hDEADBEEF);
        dir_txn(1'b1, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 32'hCAFEF00D, 11);
        chk("fetch_rdata", bus.if_rdata, 32'hCAFEF00D);

        // Both requesters held high: data grants until the starvation limit, then a fetch.
        bus.if_req = 1'b1;  bus.d_req = 1'b1;  bus.d_we = 1'b0;
        repeat (70) begin
            step();
            if (s_if_ready) bus.if_addr = $urandom() & 32'hFFFF_FFFC;
            if (s_d_ready) begin
                bus.d_addr  = $urandom();
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_wdata = $urandom();
            end
        end
        bus.if_req = 1'b0;  bus.d_req = 1'b0;
        repeat (6) step();

        // Reset in the second access cycle of a load.
        bus.d_req = 1'b1;  bus.d_we = 1'b0;  bus.d_addr = 32'h44;
        step();
        step();
        reset = 1'b1;  bus.d_req = 1'b0;
        step();
        reset = 1'b0;
        chk("rstmid_mem_en",   bus.mem_en,   1'b0);
        chk("rstmid_busy",     bus.busy,     1'b0);
        chk("rstmid_mem_addr", bus.mem_addr, 32'h0);
        chk("rstmid_d_rdata",  bus.d_rdata,  32'h0);
        repeat (5) step();

        // Randomized requesters obeying the hold-until-ready contract.
        repeat (1500) begin
            if (s_if_ready || !bus.if_req) begin
                bus.if_req  = ($urandom_range(0, 2) != 0);
                bus.if_addr = $urandom() & 32'hFFFF_FFFC;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.if_req = 1'b0;
            end
            if (s_d_ready || !bus.d_req) begin
                bus.d_req   = ($urandom_range(0, 2) != 0);
                bus.d_we    = 1'($urandom_range(0, 1));
                bus.d_addr  = $urandom();
                bus.d_wdata = $urandom();
            end else if (cyc < nxt_idle && m_own_d && $urandom_range(0, 3) == 0) begin
                bus.d_addr  = $urandom();
                bus.d_wdata = $urandom();
            end
            reset = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 1'b0;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
        repeat (8) step();

        // Single fetch on the latency-1 and latency-5 instances.
        v1 = 32'h1111_0001;
        v5 = 32'h5555_0005;
        for (int k = 0; k < 10; k++) begin
            if (k == 0) begin
                bus1.if_req = 1'b1;  bus1.if_addr = 32'h80;
                bus5.if_req = 1'b1;  bus5.if_addr = 32'h84;
            end
            bus1.mem_rdata = (k == 2) ? v1 : 32'($urandom());
            bus5.mem_rdata = (k == 6) ? v5 : 32'($urandom());
            @(negedge clk);
            chk("l1_mem_en",   bus1.mem_en,   k == 1);
            chk("l5_mem_en",   bus5.mem_en,   k == 1);
            chk("l1_if_ready", bus1.if_ready, k == 3);
            chk("l5_if_ready", bus5.if_ready, k == 7);
            if (k == 1) chk("l1_mem_addr", bus1.mem_addr, 32'h80);
            if (k == 1) chk("l5_mem_addr", bus5.mem_addr, 32'h84);
            if (k == 3) chk("l1_if_rdata", bus1.if_rdata, v1);
            if (k == 7) chk("l5_if_rdata", bus5.if_rdata, v5);
            @(posedge clk);
            #1;
            if (k == 3) bus1.if_req = 1'b0;
            if (k == 7) bus5.if_req = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
